// File: rtl/mod_counter_ud.sv
// Runtime-programmable up/down modulo counter with wrap/saturate modes,
// synchronous clear/load, carry/borrow strobes and a sticky overflow flag.
module mod_counter_ud #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         up,
    input  logic [W-1:0] mod_val,
    input  logic         sat,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         co,
    output logic         bo,
    output logic         ovf
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] last;
    logic         at_top, at_zero, step;

    // mod_val == 0 underflows to all-ones, i.e. a full 2^W modulus
    assign last    = mod_val - ONE;
    assign at_top  = (cnt_q >= last);
    assign at_zero = (cnt_q == '0);
    assign step    = en & ~clr & ~load;

    assign cnt = cnt_q;
    assign ovf = ovf_q;
    assign tc  = (up & at_top) | (~up & at_zero);
    assign co  = step & up & ~sat & at_top;
    assign bo  = step & ~up & ~sat & at_zero;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q | co | bo;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = (load_val > last) ? last : load_val;
        end else if (en) begin
            if (up) begin
                // at_top is tested first so cnt_q + 1 can never overflow W bits
                if (at_top) cnt_d = sat ? last : '0;
                else        cnt_d = cnt_q + ONE;
            end else begin
                if (cnt_q > last) cnt_d = last;
                else if (at_zero) cnt_d = sat ? '0 : last;
                else              cnt_d = cnt_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mod_counter_ud.sv
// Randomized and directed bench for mod_counter_ud against an integer reference model.
module tb_mod_counter_ud;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, clr, load, up, sat;
    logic [W-1:0] load_val, mod_val;
    logic [W-1:0] cnt;
    logic         tc, co, bo, ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference state
    int m_cnt;
    bit m_ovf;

    mod_counter_ud #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up(up), .mod_val(mod_val), .sat(sat),
        .cnt(cnt), .tc(tc), .co(co), .bo(bo), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int last_of(input logic [W-1:0] mv);
        int modulus;
        modulus = (mv == 0) ? (1 << W) : int'(mv);
        return modulus - 1;
    endfunction

    // Called in the low phase with inputs already applied; checks, then takes one edge.
    task automatic cycle();
        int lst, nxt;
        bit e_tc, e_co, e_bo, n_ovf;
        #1;
        lst  = last_of(mod_val);
        e_tc = up ? (m_cnt >= lst) : (m_cnt == 0);
        e_co = en && !clr && !load && up && !sat && (m_cnt >= lst);
        e_bo = en && !clr && !load && !up && !sat && (m_cnt == 0);
        check("cnt", 32'(cnt), 32'(m_cnt));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("tc",  32'(tc),  32'(e_tc));
        check("co",  32'(co),  32'(e_co));
        check("bo",  32'(bo),  32'(e_bo));
        $display("cyc=%0d en=%0b clr=%0b ld=%0b lv=%0d up=%0b mod=%0d sat=%0b | cnt=%0d tc=%0b co=%0b bo=%0b ovf=%0b",
                 cyc, en, clr, load, load_val, up, mod_val, sat, cnt, tc, co, bo, ovf);
        nxt   = m_cnt;
        n_ovf = m_ovf || e_co || e_bo;
        if (clr) begin
            nxt   = 0;
            n_ovf = 0;
        end else if (load) begin
            nxt = (int'(load_val) < lst) ? int'(load_val) : lst;
        end else if (en) begin
            if (up) nxt = (m_cnt < lst) ? m_cnt + 1 : (sat ? lst : 0);
            else if (m_cnt > lst) nxt = lst;
            else if (m_cnt > 0) nxt = m_cnt - 1;
            else nxt = sat ? 0 : lst;
        end
        @(posedge clk);
        m_cnt = nxt;
        m_ovf = n_ovf;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input bit e, input bit c, input bit l, input int lv,
                         input bit u, input int mv, input bit s);
        en = e; clr = c; load = l; load_val = W'(lv); up = u; mod_val = W'(mv); sat = s;
        cycle();
    endtask

    task automatic repeat_en(input int n, input bit u, input int mv, input bit s);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, u, mv, s);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; clr = 0; load = 0; load_val = '0; up = 1; mod_val = W'(10); sat = 0;
        m_cnt = 0; m_ovf = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_cnt", 32'(cnt), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_tc_up", 32'(tc), 0);
        check("rst_co", 32'(co), 0);
        check("rst_bo", 32'(bo), 0);
        up = 0;
        #1;
        check("rst_tc_dn", 32'(tc), 1);
        up = 1;
        rst_n = 1'b1;
        @(negedge clk);

        // wrap up through modulus 10
        repeat_en(12, 1, 10, 0);
        check("wrap_up_cnt", 32'(cnt), 2);
        check("wrap_up_ovf", 32'(ovf), 1);

        // wrap down from 0
        drive(0, 1, 0, 0, 1, 10, 0);
        repeat_en(3, 0, 10, 0);
        check("wrap_dn_cnt", 32'(cnt), 7);

        // saturate up then down
        drive(0, 1, 0, 0, 1, 5, 1);
        repeat_en(8, 1, 5, 1);
        check("sat_up_cnt", 32'(cnt), 4);
        repeat_en(6, 0, 5, 1);
        check("sat_dn_cnt", 32'(cnt), 0);

        // load clamp, then clr beats load and en
        drive(0, 0, 1, 200, 1, 100, 0);
        check("load_clamp", 32'(cnt), 99);
        drive(1, 1, 1, 200, 1, 100, 0);
        check("clr_prio", 32'(cnt), 0);

        // full 2^W modulus and modulus 1
        drive(0, 0, 1, 255, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        check("mod256_wrap", 32'(cnt), 0);
        repeat_en(4, 1, 1, 0);
        repeat_en(3, 0, 1, 0);

        // modulus shrink below the count
        drive(0, 0, 1, 50, 1, 100, 0);
        drive(1, 0, 0, 0, 1, 20, 0);
        check("shrink_up", 32'(cnt), 0);
        drive(0, 0, 1, 50, 1, 100, 0);
        drive(1, 0, 0, 0, 0, 20, 0);
        check("shrink_dn", 32'(cnt), 19);
        drive(0, 0, 1, 50, 1, 100, 0);
        drive(1, 0, 0, 0, 1, 20, 1);
        check("shrink_sat", 32'(cnt), 19);

        // asynchronous reset between edges with a live count and ovf set
        drive(0, 0, 1, 7, 1, 10, 0);
        en = 0; load = 0; clr = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cnt", 32'(cnt), 0);
        check("async_rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        m_cnt = 0;
        m_ovf = 0;
        @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int sel, mv;
            sel = $urandom_range(0, 5);
            case (sel)
                0: mv = 0;
                1: mv = 1;
                2: mv = 2;
                3: mv = 10;
                default: mv = $urandom_range(0, 255);
            endcase
            if ((i % 40) >= 20) mv = 10 + (i % 3);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 255),
                  $urandom_range(0, 1), mv, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
